pipeline_decode_stage: RTL
==========================

// Module: pipeline_decode_stage
// PURPOSE
//  IF/ID register, RV32I decoder and ID/EX register for the 5-stage pipeline. Sits directly downstream of fetch.
//  - Captures instruction_code/old_pc from fetch.
//  - Decodes fields, immediates and control.
//  - Detects load-use hazards and drives the fetch stall.
//  - Applies branch flush.
//  - Presents a registered control/data bundle to execute.
// PARAMETERS
//  XLEN      32            datapath width
//  NOP_INSTR 32'h00000013  addi x0,x0,0; IF/ID instruction reset/bubble value
//  RESET_PC  32'h00000000  IF/ID and ID/EX pc reset value
// PORTS
//  clk            in   1     pipeline clock, rising edge
//  reset          in   1     asynchronous, active-low reset
//  instruction_code in 32    instruction from fetch
//  old_pc         in   32    pc of instruction_code
//  branch_true    in   1     EX-resolved redirect; flush younger stages
//  rs1_data       in   32    regfile read data, port 1 (combinational)
//  rs2_data       in   32    regfile read data, port 2
//  stall          out  1     to fetch; 1 = hold PC (combinational)
//  rs1_addr       out  5     regfile read address = if_id_instr[19:15]
//  rs2_addr       out  5     regfile read address = if_id_instr[24:20]
//  id_ex_valid    out  1     bundle below holds a real instruction
//  id_ex_pc       out  32    instruction pc
//  id_ex_imm      out  32    sign-extended immediate (I/S/B/U/J)
//  id_ex_rs1_data out  32    latched rs1_data
//  id_ex_rs2_data out  32    latched rs2_data
//  id_ex_rd       out  5     destination register
//  id_ex_rs1      out  5     source register index 1, for EX forwarding
//  id_ex_rs2      out  5     source register index 2
//  id_ex_funct3   out  3     funct3 passthrough (branch/load/store size)
//  id_ex_alu_op   out  4     pipeline_pkg::alu_op_e
//  id_ex_alu_src_imm out 1   1 = ALU operand B is id_ex_imm
//  id_ex_mem_read out  1     load
//  id_ex_mem_write out 1     store
//  id_ex_reg_write out 1     writes rd; forced 0 when rd==0
//  id_ex_branch   out  1     conditional branch
//  id_ex_jump     out  1     JAL/JALR
// BEHAVIOUR
//  - Reset (reset==0, async): if_id_instr=NOP_INSTR, if_id_valid=0, pcs=RESET_PC, all id_ex_* = 0 except id_ex_pc=RESET_PC.
//  - Latency: instruction on instruction_code at edge N is in IF/ID after N and on id_ex_* after N+1.
//  - stall = if_id_valid & id_ex_valid & id_ex_mem_read & id_ex_rd!=0 & match, where match is one of:
//      (id_ex_rd==rs1 & rs1 used) or (id_ex_rd==rs2 & rs2 used).
//    rs1 is unused for LUI/AUIPC/JAL; rs2 is used only for OP/STORE/BRANCH.
//  - stall=1: IF/ID holds; ID/EX loads a bubble (valid=0, all controls 0). Stall lasts exactly 1 cycle per load-use.
//  - branch_true=1 at an edge: IF/ID <= {NOP_INSTR, valid=0}; ID/EX <= bubble. This has priority over stall.
//    stall output is gated off by branch_true.
//  - Otherwise IF/ID <= {instruction_code, old_pc, valid=1}; ID/EX <= decode(IF/ID).
//  - Opcodes decoded: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
//    Any other opcode decodes as a bubble: valid=1, all controls 0.
//  - Immediates are sign-extended from bit 31.
//    B/J imm bit0=0. U imm = {instr[31:12],12'b0}.
//  - alu_op: OP uses funct7[5] for SUB/SRA; OP-IMM uses it only for SRAI.
//    LOAD/STORE/JALR/AUIPC use ADD; BRANCH uses SUB.
//  - Reset mid-stall or mid-flush: everything returns to reset values immediately; no residual stall.
// CONFIGURATION
//  ILLEGAL_INSN_DETECT_EN defined: adds output id_ex_illegal (1 bit, reset 0).
//    Set with id_ex_valid for unknown opcodes or bad funct7 on OP; cleared by bubble or flush.
//  ILLEGAL_INSN_DETECT_EN undefined: port absent; unknown opcodes silently become bubbles.
// STRUCTURE
//  pipeline_pkg holds:
//    - opcode localparams (OPC_LUI..OPC_OP)
//    - alu_op_e enum (ADD,SUB,SLL,SLT,SLTU,XOR,SRL,SRA,OR,AND,PASSB)
//    - id_ex_ctrl_t struct
//  Sub-module pipeline_imm_gen: combinational instr -> 32-bit imm by format.
//  Hazard compare and both register stages stay in this module.
// TESTING
//  - Reset: assert reset=0 mid-run -> stall=0, id_ex_valid=0, if_id holds NOP.
//    Release -> first instruction_code appears on id_ex_* 2 edges later.
//  - Load-use: lw x5,0(x1) then add x6,x5,x2 -> stall=1 for one cycle, one bubble on id_ex (valid=0).
//    Then add issues with id_ex_rs1=5.
//  - No false hazard: lw x0,0(x1) then add x6,x0,x2 -> stall stays 0.
//    lw x5 then lui x5,1 -> stall stays 0.
//  - Flush: branch_true=1 while stall=1 -> stall=0.
//    Next edge: if_id invalid and id_ex bubble; the following valid instruction_code issues normally.
//  - Immediates: instr 32'hFE0008E3 (beq x0,x0,-16) -> id_ex_imm=32'hFFFFFFF0, id_ex_branch=1.
//    32'h800000EF (jal x1,-1MiB) -> id_ex_imm=32'hFFF00000, id_ex_jump=1.
//  - Macro on: instr 32'h0000007F -> id_ex_valid=1, id_ex_illegal=1, reg_write=0, mem_write=0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared decode-stage definitions: RV32I opcodes, ALU operation encoding,
// the ID/EX control bundle and small decode helpers.
package pipeline_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  typedef struct packed {
    alu_op_e alu_op;
    logic    alu_src_imm;
    logic    mem_read;
    logic    mem_write;
    logic    reg_write;
    logic    branch;
    logic    jump;
  } id_ex_ctrl_t;

  // funct3 -> ALU op; alt selects SUB/SRA on the 000/101 encodings
  function automatic alu_op_e f3_to_alu(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  function automatic logic is_known_opc(input logic [6:0] opc);
    return (opc == OPC_LUI) || (opc == OPC_AUIPC) || (opc == OPC_JAL) ||
           (opc == OPC_JALR) || (opc == OPC_BRANCH) || (opc == OPC_LOAD) ||
           (opc == OPC_STORE) || (opc == OPC_OP_IMM) || (opc == OPC_OP);
  endfunction

endpackage

// File: rtl/pipeline_decode_stage_if.sv
// Decode-stage bus: fetch inputs, regfile read port, stall back to fetch
// and the registered ID/EX bundle. id_ex_illegal exists only when
// ILLEGAL_INSN_DETECT_EN is defined.
interface pipeline_decode_stage_if
  import pipeline_pkg::*;
#(
  parameter int XLEN = 32
);
  logic [31:0]     instruction_code;
  logic [XLEN-1:0] old_pc;
  logic            branch_true;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            stall;
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic            id_ex_valid;
  logic [XLEN-1:0] id_ex_pc;
  logic [31:0]     id_ex_imm;
  logic [XLEN-1:0] id_ex_rs1_data;
  logic [XLEN-1:0] id_ex_rs2_data;
  logic [4:0]      id_ex_rd;
  logic [4:0]      id_ex_rs1;
  logic [4:0]      id_ex_rs2;
  logic [2:0]      id_ex_funct3;
  alu_op_e         id_ex_alu_op;
  logic            id_ex_alu_src_imm;
  logic            id_ex_mem_read;
  logic            id_ex_mem_write;
  logic            id_ex_reg_write;
  logic            id_ex_branch;
  logic            id_ex_jump;
`ifdef ILLEGAL_INSN_DETECT_EN
  logic            id_ex_illegal;
`endif

  // fetch / regfile / execute side
  modport master (
    output instruction_code, old_pc, branch_true, rs1_data, rs2_data,
    input  stall, rs1_addr, rs2_addr, id_ex_valid, id_ex_pc, id_ex_imm,
           id_ex_rs1_data, id_ex_rs2_data, id_ex_rd, id_ex_rs1, id_ex_rs2,
           id_ex_funct3, id_ex_alu_op, id_ex_alu_src_imm, id_ex_mem_read,
           id_ex_mem_write, id_ex_reg_write, id_ex_branch, id_ex_jump
`ifdef ILLEGAL_INSN_DETECT_EN
    , input id_ex_illegal
`endif
  );

  // decode stage
  modport slave (
    input  instruction_code, old_pc, branch_true, rs1_data, rs2_data,
    output stall, rs1_addr, rs2_addr, id_ex_valid, id_ex_pc, id_ex_imm,
           id_ex_rs1_data, id_ex_rs2_data, id_ex_rd, id_ex_rs1, id_ex_rs2,
           id_ex_funct3, id_ex_alu_op, id_ex_alu_src_imm, id_ex_mem_read,
           id_ex_mem_write, id_ex_reg_write, id_ex_branch, id_ex_jump
`ifdef ILLEGAL_INSN_DETECT_EN
    , output id_ex_illegal
`endif
  );
endinterface

// File: rtl/pipeline_imm_gen.sv
// RV32I immediate generator: picks the I/S/B/U/J format from the opcode and
// sign-extends from instr[31]. Formats without an immediate yield 0.
module pipeline_imm_gen
  import pipeline_pkg::*;
(
  input  logic [31:0] instr,
  output logic [31:0] imm
);
  // format select by opcode
  always_comb begin
    imm = '0;
    case (instr[6:0])
      OPC_LUI, OPC_AUIPC:
        imm = {instr[31:12], 12'b0};
      OPC_JAL:
        imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      OPC_BRANCH:
        imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      OPC_STORE:
        imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OPC_JALR, OPC_LOAD, OPC_OP_IMM:
        imm = {{20{instr[31]}}, instr[31:20]};
      default: imm = '0;
    endcase
  end
endmodule

// File: rtl/pipeline_decode_stage.sv
// IF/ID register, RV32I decoder and ID/EX register. Detects load-use hazards
// (one-cycle stall + bubble) and applies branch flush, which wins over stall.
// Optional: define ILLEGAL_INSN_DETECT_EN to add id_ex_illegal.
module pipeline_decode_stage
  import pipeline_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013,
  parameter logic [XLEN-1:0] RESET_PC  = '0
) (
  input logic                    clk,
  input logic                    reset,
  pipeline_decode_stage_if.slave bus
);
  logic [31:0]     if_id_instr;
  logic [XLEN-1:0] if_id_pc;
  logic            if_id_valid;

  logic            id_ex_valid;
  id_ex_ctrl_t     id_ex_ctrl;
  logic [XLEN-1:0] id_ex_pc, id_ex_rs1_data, id_ex_rs2_data;
  logic [31:0]     id_ex_imm;
  logic [4:0]      id_ex_rd, id_ex_rs1, id_ex_rs2;
  logic [2:0]      id_ex_funct3;

  logic [6:0]  opc;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic        rs1_used, rs2_used, load_use;
  id_ex_ctrl_t dec_ctrl;
  logic [31:0] dec_imm;

  assign opc = if_id_instr[6:0];
  assign rd  = if_id_instr[11:7];
  assign f3  = if_id_instr[14:12];
  assign rs1 = if_id_instr[19:15];
  assign rs2 = if_id_instr[24:20];

  pipeline_imm_gen u_imm_gen (.instr(if_id_instr), .imm(dec_imm));

  // load-use: the load in ID/EX writes a register the IF/ID instruction reads
  assign rs1_used = !((opc == OPC_LUI) || (opc == OPC_AUIPC) || (opc == OPC_JAL));
  assign rs2_used = (opc == OPC_OP) || (opc == OPC_STORE) || (opc == OPC_BRANCH);
  assign load_use = if_id_valid && id_ex_valid && id_ex_ctrl.mem_read && (id_ex_rd != 5'd0) &&
                    (((id_ex_rd == rs1) && rs1_used) || ((id_ex_rd == rs2) && rs2_used));
  assign bus.stall = load_use && !bus.branch_true;

  // control decode; unknown opcodes leave every control at 0
  always_comb begin
    dec_ctrl = '0;
    case (opc)
      OPC_LUI:    begin dec_ctrl.alu_op = ALU_PASSB; dec_ctrl.alu_src_imm = 1'b1; dec_ctrl.reg_write = 1'b1; end
      OPC_AUIPC:  begin dec_ctrl.alu_op = ALU_ADD; dec_ctrl.alu_src_imm = 1'b1; dec_ctrl.reg_write = 1'b1; end
      OPC_JAL,
      OPC_JALR:   begin dec_ctrl.alu_op = ALU_ADD; dec_ctrl.alu_src_imm = 1'b1; dec_ctrl.reg_write = 1'b1;
                        dec_ctrl.jump = 1'b1; end
      OPC_BRANCH: begin dec_ctrl.alu_op = ALU_SUB; dec_ctrl.branch = 1'b1; end
      OPC_LOAD:   begin dec_ctrl.alu_op = ALU_ADD; dec_ctrl.alu_src_imm = 1'b1; dec_ctrl.mem_read = 1'b1;
                        dec_ctrl.reg_write = 1'b1; end
      OPC_STORE:  begin dec_ctrl.alu_op = ALU_ADD; dec_ctrl.alu_src_imm = 1'b1; dec_ctrl.mem_write = 1'b1; end
      // funct7[5] only matters for SRAI; on ADDI it is immediate data
      OPC_OP_IMM: begin dec_ctrl.alu_op = f3_to_alu(f3, if_id_instr[30] && (f3 == 3'b101));
                        dec_ctrl.alu_src_imm = 1'b1; dec_ctrl.reg_write = 1'b1; end
      OPC_OP:     begin dec_ctrl.alu_op = f3_to_alu(f3, if_id_instr[30]); dec_ctrl.reg_write = 1'b1; end
      default:    dec_ctrl = '0;
    endcase
    if (rd == 5'd0) dec_ctrl.reg_write = 1'b0;
  end

  // IF/ID: flush to NOP, hold on stall, otherwise capture fetch
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_id_instr <= NOP_INSTR;
      if_id_pc    <= RESET_PC;
      if_id_valid <= 1'b0;
    end else if (bus.branch_true) begin
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
    end else if (!load_use) begin
      if_id_instr <= bus.instruction_code;
      if_id_pc    <= bus.old_pc;
      if_id_valid <= 1'b1;
    end
  end

  // ID/EX: bubble on flush or stall, otherwise take the decoded bundle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      id_ex_valid    <= 1'b0;
      id_ex_ctrl     <= '0;
      id_ex_pc       <= RESET_PC;
      id_ex_imm      <= '0;
      id_ex_rs1_data <= '0;
      id_ex_rs2_data <= '0;
      id_ex_rd       <= '0;
      id_ex_rs1      <= '0;
      id_ex_rs2      <= '0;
      id_ex_funct3   <= '0;
    end else if (bus.branch_true || load_use) begin
      id_ex_valid <= 1'b0;
      id_ex_ctrl  <= '0;
    end else begin
      id_ex_valid    <= if_id_valid;
      id_ex_ctrl     <= if_id_valid ? dec_ctrl : '0;
      id_ex_pc       <= if_id_pc;
      id_ex_imm      <= dec_imm;
      id_ex_rs1_data <= bus.rs1_data;
      id_ex_rs2_data <= bus.rs2_data;
      id_ex_rd       <= rd;
      id_ex_rs1      <= rs1;
      id_ex_rs2      <= rs2;
      id_ex_funct3   <= f3;
    end
  end

`ifdef ILLEGAL_INSN_DETECT_EN
  logic dec_illegal, id_ex_illegal;

  // unknown opcode, or OP with funct7 other than 0 / 0x20-on-ADD/SRL
  always_comb begin
    dec_illegal = !is_known_opc(opc);
    if (opc == OPC_OP)
      dec_illegal = !((if_id_instr[31:25] == 7'h00) ||
                      ((if_id_instr[31:25] == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101))));
  end

  // illegal flag travels with id_ex_valid and clears on bubble/flush
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                             id_ex_illegal <= 1'b0;
    else if (bus.branch_true || load_use)   id_ex_illegal <= 1'b0;
    else                                    id_ex_illegal <= if_id_valid && dec_illegal;
  end

  assign bus.id_ex_illegal = id_ex_illegal;
`endif

  assign bus.rs1_addr          = rs1;
  assign bus.rs2_addr          = rs2;
  assign bus.id_ex_valid       = id_ex_valid;
  assign bus.id_ex_pc          = id_ex_pc;
  assign bus.id_ex_imm         = id_ex_imm;
  assign bus.id_ex_rs1_data    = id_ex_rs1_data;
  assign bus.id_ex_rs2_data    = id_ex_rs2_data;
  assign bus.id_ex_rd          = id_ex_rd;
  assign bus.id_ex_rs1         = id_ex_rs1;
  assign bus.id_ex_rs2         = id_ex_rs2;
  assign bus.id_ex_funct3      = id_ex_funct3;
  assign bus.id_ex_alu_op      = id_ex_ctrl.alu_op;
  assign bus.id_ex_alu_src_imm = id_ex_ctrl.alu_src_imm;
  assign bus.id_ex_mem_read    = id_ex_ctrl.mem_read;
  assign bus.id_ex_mem_write   = id_ex_ctrl.mem_write;
  assign bus.id_ex_reg_write   = id_ex_ctrl.reg_write;
  assign bus.id_ex_branch      = id_ex_ctrl.branch;
  assign bus.id_ex_jump        = id_ex_ctrl.jump;

endmodule
